// File: rtl/dp_vec_pingpong_buf.sv
// Double-buffered multi-lane vector buffer between the input streamer and the
// MAC engine. One bank fills while the other streams out; bank pointers toggle
// on completion so read order always follows fill order.
//
// state    | meaning
// W_IDLE   | no fill in progress, waiting for wr_start
// W_FILL   | accepting producer beats into mem[wbank]
// R_IDLE   | no stream-out in progress, waiting for rd_start
// R_STREAM | feeding mem[rbank] through the output register
module dp_vec_pingpong_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_start,
    input  logic [LEN_WIDTH-1:0]         wr_len,
    input  logic                         wr_abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         wr_busy,
    output logic                         wr_done,
    input  logic                         rd_start,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic                         out_last,
    output logic                         rd_busy,
    output logic                         rd_done,
    output logic [1:0]                   bank_full,
    output logic                         err
);
    localparam int W = NUM_CH * DATA_WIDTH;

    typedef enum logic {W_IDLE, W_FILL}   w_state_t;
    typedef enum logic {R_IDLE, R_STREAM} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic [W-1:0]          mem [2][DEPTH];
    logic [LEN_WIDTH-1:0]  len_q [2];
    logic                  wbank, rbank;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [1:0]            full_q;
    logic                  wr_done_p, rd_done_p;

    logic                 len_ok, wr_accept, wr_reject, wr_beat, wr_final;
    logic                 rd_accept, rd_reject, rd_load, rd_final, out_hs;
    logic [LEN_WIDTH-1:0] wlen_cur, rlen_cur;

    assign len_ok    = (wr_len != '0) && (wr_len <= LEN_WIDTH'(DEPTH));
    assign wlen_cur  = len_q[wbank];
    assign rlen_cur  = len_q[rbank];
    assign out_hs    = out_valid && out_ready;
    assign in_ready  = (w_state == W_FILL);
    assign wr_busy   = (w_state == W_FILL);
    assign rd_busy   = (r_state == R_STREAM);
    assign bank_full = full_q;

    // Write FSM next state: accept/reject requests, abort beats data, detect final beat.
    always_comb begin
        w_state_nxt = w_state;
        wr_accept   = 1'b0;
        wr_reject   = 1'b0;
        wr_beat     = 1'b0;
        wr_final    = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (wr_start) begin
                    if (len_ok && !full_q[wbank]) begin
                        wr_accept   = 1'b1;
                        w_state_nxt = W_FILL;
                    end else begin
                        wr_reject = 1'b1;
                    end
                end
            end
            W_FILL: begin
                wr_reject = wr_start;
                if (wr_abort) begin
                    w_state_nxt = W_IDLE;
                end else if (in_valid) begin
                    wr_beat = 1'b1;
                    if (LEN_WIDTH'(wr_ptr) == wlen_cur - LEN_WIDTH'(1)) begin
                        wr_final    = 1'b1;
                        w_state_nxt = W_IDLE;
                    end
                end
            end
        endcase
    end

    // Read FSM next state. Once the last element sits in the output register the
    // load condition is blocked by backpressure until its handshake, so rd_ptr
    // wrapping after a full-depth vector never triggers a stray load.
    always_comb begin
        r_state_nxt = r_state;
        rd_accept   = 1'b0;
        rd_reject   = 1'b0;
        rd_load     = 1'b0;
        rd_final    = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (rd_start) begin
                    if (full_q[rbank]) begin
                        rd_accept   = 1'b1;
                        r_state_nxt = R_STREAM;
                    end else begin
                        rd_reject = 1'b1;
                    end
                end
            end
            R_STREAM: begin
                rd_reject = rd_start;
                if (out_hs && out_last) begin
                    rd_final    = 1'b1;
                    r_state_nxt = R_IDLE;
                end else if ((LEN_WIDTH'(rd_ptr) < rlen_cur) && (!out_valid || out_ready)) begin
                    rd_load = 1'b1;
                end
            end
        endcase
    end

    // State registers for both FSMs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    // Write pointer, write bank pointer and the delayed wr_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            wbank     <= 1'b0;
            wr_done_p <= 1'b0;
            wr_done   <= 1'b0;
        end else begin
            wr_done_p <= wr_final;
            wr_done   <= wr_done_p;
            if (wr_accept)
                wr_ptr <= '0;
            else if (wr_beat)
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (wr_final)
                wbank <= ~wbank;
        end
    end

    // Bank storage and per-bank length; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept)
            len_q[wbank] <= wr_len;
        if (wr_beat)
            mem[wbank][wr_ptr] <= in_data;
    end

    // Read pointer, read bank pointer, output register and delayed rd_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            rbank     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            rd_done_p <= 1'b0;
            rd_done   <= 1'b0;
        end else begin
            rd_done_p <= rd_final;
            rd_done   <= rd_done_p;
            if (rd_accept)
                rd_ptr <= '0;
            else if (rd_load)
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            if (rd_final)
                rbank <= ~rbank;
            if (rd_load) begin
                out_valid <= 1'b1;
                out_data  <= mem[rbank][rd_ptr];
                out_last  <= (LEN_WIDTH'(rd_ptr) == rlen_cur - LEN_WIDTH'(1));
            end else if (out_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Full flags (set by fill completion, cleared by read completion) and err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 2'b00;
            err    <= 1'b0;
        end else begin
            if (wr_final)
                full_q[wbank] <= 1'b1;
            if (rd_final)
                full_q[rbank] <= 1'b0;
            err <= wr_reject | rd_reject;
        end
    end

endmodule

// File: tb/tb_dp_vec_pingpong_buf.sv
// Directed bench for dp_vec_pingpong_buf: a transaction-level model built from
// queues predicts every output each cycle; directed sections add literal checks.
module tb_dp_vec_pingpong_buf;
    localparam int DEPTH = 32;
    localparam int LW    = 6;
    localparam int W     = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_start = 1'b0, wr_abort = 1'b0, in_valid = 1'b0;
    logic          rd_start = 1'b0, out_ready = 1'b0;
    logic [LW-1:0] wr_len = '0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, wr_busy, wr_done, out_valid, out_last, rd_busy, rd_done, err;
    logic [W-1:0]  out_data;
    logic [1:0]    bank_full;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dp_vec_pingpong_buf #(.DATA_WIDTH(8), .NUM_CH(2), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_start(wr_start), .wr_len(wr_len), .wr_abort(wr_abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_busy(wr_busy), .wr_done(wr_done),
        .rd_start(rd_start), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .rd_busy(rd_busy), .rd_done(rd_done),
        .bank_full(bank_full), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit           m_wfill, m_wbank, m_rbank, m_rstream, m_ovalid, m_olast, m_err;
    bit [1:0]     m_full;
    bit           m_wdp, m_wd, m_rdp, m_rd;
    int           m_wlen;
    logic [W-1:0] m_odata;
    logic [W-1:0] m_wq[$], m_b0[$], m_b1[$], m_rq[$];

    // Advance the model on each edge, then compare all outputs just after it.
    always @(posedge clk) begin : model
        bit       wf0, wb0, rb0, rs0, hs;
        bit [1:0] f0;
        if (!rst_n) begin
            m_wfill = 0; m_wbank = 0; m_rbank = 0; m_rstream = 0;
            m_ovalid = 0; m_olast = 0; m_err = 0; m_full = 2'b00;
            m_wdp = 0; m_wd = 0; m_rdp = 0; m_rd = 0;
            m_wq.delete(); m_rq.delete();
        end else begin
            wf0 = m_wfill; wb0 = m_wbank; rb0 = m_rbank; rs0 = m_rstream; f0 = m_full;
            hs = m_ovalid && out_ready;
            m_err = 0;
            m_wd = m_wdp; m_wdp = 0;
            m_rd = m_rdp; m_rdp = 0;
            if (wf0) begin
                if (wr_abort) begin
                    m_wfill = 0;
                end else if (in_valid) begin
                    m_wq.push_back(in_data);
                    if (m_wq.size() == m_wlen) begin
                        if (wb0) m_b1 = m_wq;
                        else     m_b0 = m_wq;
                        m_full[wb0] = 1'b1;
                        m_wbank = !wb0;
                        m_wfill = 0;
                        m_wdp = 1;
                    end
                end
            end
            if (wr_start) begin
                if (!wf0 && wr_len >= 1 && wr_len <= DEPTH && !f0[wb0]) begin
                    m_wfill = 1;
                    m_wlen = int'(wr_len);
                    m_wq.delete();
                end else begin
                    m_err = 1;
                end
            end
            if (rs0) begin
                if (hs && m_olast) begin
                    m_ovalid = 0; m_olast = 0; m_rstream = 0;
                    m_full[rb0] = 1'b0;
                    m_rbank = !rb0;
                    m_rdp = 1;
                end else if (m_rq.size() > 0 && (!m_ovalid || out_ready)) begin
                    m_odata = m_rq.pop_front();
                    m_ovalid = 1;
                    m_olast = (m_rq.size() == 0);
                end else if (hs) begin
                    m_ovalid = 0;
                end
            end
            if (rd_start) begin
                if (!rs0 && f0[rb0]) begin
                    m_rstream = 1;
                    if (rb0) m_rq = m_b1;
                    else     m_rq = m_b0;
                end else begin
                    m_err = 1;
                end
            end
        end
        #1;
        chk("in_ready",  in_ready,  m_wfill);
        chk("wr_busy",   wr_busy,   m_wfill);
        chk("rd_busy",   rd_busy,   m_rstream);
        chk("wr_done",   wr_done,   m_wd);
        chk("rd_done",   rd_done,   m_rd);
        chk("bank_full", bank_full, m_full);
        chk("err",       err,       m_err);
        chk("out_valid", out_valid, m_ovalid);
        if (m_ovalid) begin
            chk("out_data", out_data, m_odata);
            chk("out_last", out_last, m_olast);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [W-1:0] got[$];
    int           got_last;
    logic [W-1:0] stall_snap;

    task automatic fill(input int len, input int b0, input int b1);
        wr_start = 1; wr_len = LW'(len);
        @(negedge clk);
        wr_start = 0;
        for (int i = 0; i < len; i++) begin
            in_valid = 1;
            in_data = {8'(b1 + i), 8'(b0 + i)};
            @(negedge clk);
        end
        in_valid = 0;
    endtask

    // mode 0: out_ready always high; mode 1: ready low on cycles 2 and 3.
    task automatic read_vec(input int max_cyc, input int mode);
        bit fin;
        got.delete();
        got_last = -1;
        fin = 0;
        rd_start = 1;
        @(negedge clk);
        rd_start = 0;
        for (int c = 0; c < max_cyc && !fin; c++) begin
            out_ready = (mode == 1 && (c == 2 || c == 3)) ? 1'b0 : 1'b1;
            if (mode == 1 && c == 3) stall_snap = out_data;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (out_last) begin
                    got_last = got.size() - 1;
                    fin = 1;
                end
            end
            @(negedge clk);
        end
        out_ready = 0;
        if (!fin) begin
            n_vec++; n_bad++;
            $display("FAIL read_timeout: no out_last within %0d cycles", max_cyc);
        end
    endtask

    task automatic pulse_wr_reject(input int len, input string name);
        wr_start = 1; wr_len = LW'(len);
        @(negedge clk);
        wr_start = 0;
        chk({name, "_err"}, err, 1'b1);
        chk({name, "_busy"}, wr_busy, 1'b0);
        @(negedge clk);
        chk({name, "_err_clr"}, err, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_bank_full", bank_full, 2'b00);
        chk("rst_err", err, 1'b0);
        rst_n = 1;
        @(negedge clk);

        // basic fill and read
        fill(4, 1, 5);
        chk("basic_full", bank_full, 2'b01);
        chk("basic_wr_done_early", wr_done, 1'b0);
        @(negedge clk);
        chk("basic_wr_done", wr_done, 1'b1);
        @(negedge clk);
        chk("basic_wr_done_clr", wr_done, 1'b0);
        read_vec(20, 0);
        chk("basic_count", got.size(), 4);
        chk("basic_first", got[0], 16'h0501);
        chk("basic_lastdata", got[3], 16'h0804);
        chk("basic_lastidx", got_last, 3);
        chk("basic_empty", bank_full, 2'b00);
        @(negedge clk);
        chk("basic_rd_done", rd_done, 1'b1);

        // overlap: full-depth read of one bank while the other fills
        fill(32, 10, 50);
        chk("ovl_full", bank_full, 2'b10);
        fork
            read_vec(80, 0);
            begin
                repeat (3) @(negedge clk);
                fill(5, 100, 200);
            end
        join
        chk("ovl_count", got.size(), 32);
        chk("ovl_first", got[0], 16'h320A);
        chk("ovl_last", got[31], 16'h5129);
        chk("ovl_lastidx", got_last, 31);
        chk("ovl_full2", bank_full, 2'b01);
        read_vec(20, 0);
        chk("ovl_b_count", got.size(), 5);
        chk("ovl_b_last", got[4], 16'hCC68);
        repeat (2) @(negedge clk);

        // backpressure
        fill(3, 8'h11, 8'h21);
        read_vec(20, 1);
        chk("bp_count", got.size(), 3);
        chk("bp_mid", got[1], 16'h2212);
        chk("bp_hold", stall_snap, 16'h2212);
        chk("bp_lastidx", got_last, 2);
        repeat (2) @(negedge clk);

        // rejects
        rd_start = 1;
        @(negedge clk);
        rd_start = 0;
        chk("rej_rd_empty_err", err, 1'b1);
        chk("rej_rd_empty_busy", rd_busy, 1'b0);
        @(negedge clk);
        pulse_wr_reject(0, "rej_len0");
        pulse_wr_reject(33, "rej_len33");
        wr_start = 1; wr_len = 6'd2;
        @(negedge clk);
        wr_start = 0; in_valid = 1; in_data = 16'hA1B1;
        @(negedge clk);
        in_data = 16'hA2B2; rd_start = 1;
        @(negedge clk);
        in_valid = 0; rd_start = 0;
        chk("rej_coinc_err", err, 1'b1);
        chk("rej_coinc_busy", rd_busy, 1'b0);
        chk("rej_coinc_full", bank_full, 2'b01);
        fill(2, 8'h70, 8'h80);
        chk("rej_both_full", bank_full, 2'b11);
        pulse_wr_reject(2, "rej_full");
        chk("rej_full_keep", bank_full, 2'b11);
        read_vec(20, 0);
        chk("rej_drain0", got[0], 16'hA1B1);
        read_vec(20, 0);
        chk("rej_drain1", got[1], 16'h8171);
        repeat (2) @(negedge clk);

        // abort after two beats, coincident with a third valid beat
        wr_start = 1; wr_len = 6'd5;
        @(negedge clk);
        wr_start = 0; in_valid = 1; in_data = 16'hEE01;
        @(negedge clk);
        in_data = 16'hEE02;
        @(negedge clk);
        in_data = 16'hEE03; wr_abort = 1;
        @(negedge clk);
        in_valid = 0; wr_abort = 0;
        chk("abort_busy", wr_busy, 1'b0);
        chk("abort_full", bank_full, 2'b00);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", wr_done, 1'b0);
        end
        fill(2, 8'h40, 8'h50);
        chk("abort_refill_full", bank_full, 2'b01);
        read_vec(20, 0);
        chk("abort_count", got.size(), 2);
        chk("abort_d0", got[0], 16'h5040);
        chk("abort_d1", got[1], 16'h5141);
        repeat (2) @(negedge clk);

        // async reset while streaming and filling
        fill(8, 8'h60, 8'h70);
        rd_start = 1; wr_start = 1; wr_len = 6'd4;
        @(negedge clk);
        rd_start = 0; wr_start = 0; in_valid = 1; in_data = 16'h1234; out_ready = 1;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_wr_busy", wr_busy, 1'b0);
        chk("arst_rd_busy", rd_busy, 1'b0);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_data", out_data, 16'h0000);
        chk("arst_out_last", out_last, 1'b0);
        chk("arst_bank_full", bank_full, 2'b00);
        chk("arst_done", {wr_done, rd_done, err}, 3'b000);
        in_valid = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
